// File: rtl/arbitro_mux2_pkg.sv
// Shared types for the two-requester round-robin arbiter in front of mux2_1.
// Holds the FSM state encodings, the last-served pointer encodings and the counter width.
package arbitro_mux2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } side_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mux2_1.sv
// Plain 2:1 bit-vector multiplexer: s=0 passes a, s=1 passes b.
module mux2_1 #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/arbitro_mux2.sv
// Round-robin arbiter owning the select of a mux2_1 shared by requesters A and B.
// Grants are burst-limited to MAX_HOLD cycles only while the other side competes.
module arbitro_mux2
  import arbitro_mux2_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  side_t            last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] mux_y;

  mux2_1 #(.WIDTH(WIDTH)) u_mux (
    .s (sel),
    .a (a),
    .b (b),
    .y (mux_y)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_a && (!req_b || last == LAST_B)) begin
          state_nxt = GNT_A;
          cnt_nxt   = CNT_ONE;
        end else if (req_b) begin
          state_nxt = GNT_B;
          cnt_nxt   = CNT_ONE;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          last_nxt  = LAST_A;
          state_nxt = req_b ? GNT_B : IDLE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt < HOLD_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // Burst limit reached: hand over only if B is waiting, otherwise restart the burst.
          cnt_nxt = CNT_ONE;
          if (req_b) begin
            state_nxt = GNT_B;
            last_nxt  = LAST_A;
          end
        end
      end
      GNT_B: begin
        if (!req_b) begin
          last_nxt  = LAST_B;
          state_nxt = req_a ? GNT_A : IDLE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt < HOLD_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          cnt_nxt = CNT_ONE;
          if (req_a) begin
            state_nxt = GNT_A;
            last_nxt  = LAST_B;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= LAST_B;
      cnt   <= '0;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      sel   <= 1'b0;
      valid <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      // Grants and select decode the next state so they line up with the state register.
      gnt_a <= (state_nxt == GNT_A);
      gnt_b <= (state_nxt == GNT_B);
      if (state_nxt == GNT_A)      sel <= 1'b0;
      else if (state_nxt == GNT_B) sel <= 1'b1;
      valid <= gnt_a | gnt_b;
      if (gnt_a || gnt_b) out <= mux_y;
    end
  end

endmodule

// File: tb/tb_arbitro_mux2.sv
// Directed, table-driven bench for arbitro_mux2 with hand-computed expectations.
// Multi-cycle corner cases (long hold, alternation, async reset, one-cycle tie) are hand sequences.
module tb_arbitro_mux2;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             sel, gnt_a, gnt_b, valid;
  logic [WIDTH-1:0] out;

  int n_pass = 0;
  int n_total = 0;

  arbitro_mux2 #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (req_a),
    .req_b (req_b),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ra, rb;
    logic [7:0] da, db;
    logic       e_ga, e_gb, e_sel, e_valid;
    logic [7:0] e_out;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 1'b0;
    req_b = 1'b0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic ga, input logic gb,
                            input logic s, input logic v, input logic [7:0] o);
    check({tag, " gnt_a"}, 32'(gnt_a), 32'(ga));
    check({tag, " gnt_b"}, 32'(gnt_b), 32'(gb));
    check({tag, " sel"},   32'(sel),   32'(s));
    check({tag, " valid"}, 32'(valid), 32'(v));
    check({tag, " out"},   32'(out),   32'(o));
  endtask

  initial begin
    //          ra    rb    a      b      ga    gb    sel   valid out
    vecs[0]  = '{1'b1, 1'b0, 8'h5A, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h5A, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[2]  = '{1'b0, 1'b0, 8'h5A, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[3]  = '{1'b0, 1'b0, 8'h5A, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    // last = A now, so the tie goes to B
    vecs[4]  = '{1'b1, 1'b1, 8'hA1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[5]  = '{1'b1, 1'b1, 8'hA1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1};
    vecs[6]  = '{1'b1, 1'b1, 8'hA1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2};
    vecs[7]  = '{1'b1, 1'b1, 8'hA1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2};
    // burst of 4 exhausted with A waiting: handover without an idle cycle
    vecs[8]  = '{1'b1, 1'b1, 8'hA1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
    vecs[9]  = '{1'b1, 1'b1, 8'hA2, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2};
    // A drops with B waiting: B takes over on the next edge
    vecs[10] = '{1'b0, 1'b1, 8'hA2, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2};
    vecs[11] = '{1'b0, 1'b1, 8'hA2, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3};

    #3;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_reset();
    check_outs("post_release", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      a     = vecs[i].da;
      b     = vecs[i].db;
      step();
      check_outs($sformatf("row%0d", i), vecs[i].e_ga, vecs[i].e_gb,
                 vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_out);
    end

    // B alone for 10 cycles: the burst counter wraps but the grant is never released
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h20 + i);
      step();
      check($sformatf("hold%0d gnt_b", i), 32'(gnt_b), 32'd1);
      check($sformatf("hold%0d gnt_a", i), 32'(gnt_a), 32'd0);
      check($sformatf("hold%0d sel", i),   32'(sel),   32'd1);
      check($sformatf("hold%0d out", i),   32'(out),   32'(8'h20 + i));
    end

    // Continuous tie from reset: 4 cycles A, 4 cycles B, alternating
    do_reset();
    a = 8'hAA;
    b = 8'hBB;
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("alt%0d gnt_a", i), 32'(gnt_a), 32'(((i / 4) % 2) == 0));
      check($sformatf("alt%0d gnt_b", i), 32'(gnt_b), 32'(((i / 4) % 2) == 1));
    end
    check("alt valid", 32'(valid), 32'd1);
    check("alt out", 32'(out), 32'hBB);

    // Asynchronous reset mid-burst, between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_tie gnt_a", 32'(gnt_a), 32'd1);
    check("rst_tie gnt_b", 32'(gnt_b), 32'd0);

    // One-cycle tie from reset: single grant pulse to A, one valid pulse
    do_reset();
    a = 8'h3C;
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    check_outs("pulse0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    check_outs("pulse1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    step();
    check_outs("pulse2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
